// File: rtl/act_pack_pkg.sv
// Shared types and sizing helpers for the activation-SRAM fill stage.
package act_pack_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PACK  = 3'd1,
    DRAIN = 3'd2,
    PAD   = 3'd3,
    DONE  = 3'd4
  } pack_state_t;

  localparam int TM_DEF         = 14;
  localparam int IN_BYTES_DEF   = 4;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int ACC_BYTES      = TM_DEF + IN_BYTES_DEF - 1;

  // Accumulator must hold a just-short-of-full row plus one whole beat.
  function automatic int acc_bytes(input int tm, input int in_bytes);
    return tm + in_bytes - 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/act_pack_writer_if.sv
// Input beat stream of the activation fill stage (valid/ready with last marker).
interface act_pack_writer_if #(
  parameter int IN_BYTES = 4
) ();
  logic                  valid;
  logic                  ready;
  logic                  last;
  logic [IN_BYTES*8-1:0] data;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/act_row_packer.sv
// Byte accumulator: appends input beats at the fill point and hands out TM-byte rows.
module act_row_packer
  import act_pack_pkg::*;
#(
  parameter int TM       = 14,
  parameter int IN_BYTES = 4,
  localparam int ACC     = acc_bytes(TM, IN_BYTES),
  localparam int CW      = cnt_width(ACC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  append,
  input  logic [IN_BYTES*8-1:0] beat,
  output logic [CW-1:0]         cnt,
  output logic [CW-1:0]         pre_cnt,
  output logic                  row_ready,
  output logic [TM*8-1:0]       row_data
);

  logic [ACC*8-1:0] acc;
  logic [ACC*8-1:0] beat_ext;
  logic [ACC*8-1:0] merged;

  // Bytes above cnt are always zero, so OR-ing the shifted beat is enough and
  // a partial row read straight from acc is already zero-padded.
  always_comb begin
    beat_ext                 = '0;
    beat_ext[IN_BYTES*8-1:0] = beat;
    merged                   = acc;
    pre_cnt                  = cnt;
    if (append) begin
      merged  = acc | (beat_ext << {cnt, 3'b000});
      pre_cnt = cnt + CW'(IN_BYTES);
    end
    row_ready = (pre_cnt >= CW'(TM));
    row_data  = merged[TM*8-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (row_ready) begin
      acc <= merged >> (TM * 8);
      cnt <= pre_cnt - CW'(TM);
    end else begin
      acc <= merged;
      cnt <= pre_cnt;
    end
  end

endmodule

// File: rtl/act_pack_writer.sv
// Fill stage for the ping-pong activation SRAM: packs beats into rows and tracks bank ownership.
// Optional ACT_PACK_STATS_EN adds beat/stall counters (stat_beats, stat_stall).
//
// state | meaning
// IDLE  | waiting for a tile start on a free bank
// PACK  | accepting beats, writing rows as they fill
// DRAIN | all rows written, discarding beats until s_last
// PAD   | early s_last, writing zero-padded rows to complete the tile
// DONE  | tile complete, mark bank full and flip banks
module act_pack_writer
  import act_pack_pkg::*;
#(
  parameter int TM         = TM_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int IN_BYTES   = IN_BYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [ADDR_WIDTH:0]   cfg_rows,
  act_pack_writer_if.slave      s_if,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [TM*8-1:0]       wdata,
  output logic                  bank_sel_wr,
  input  logic [1:0]            bank_release,
  output logic [1:0]            bank_full,
  output logic                  tile_done,
  output logic                  err_overflow,
  output logic                  err_underflow
`ifdef ACT_PACK_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [31:0]           stat_stall
`endif
);

  localparam int CW = cnt_width(acc_bytes(TM, IN_BYTES));

  if (IN_BYTES < 1 || IN_BYTES > TM) begin : g_cfg_check
    $error("act_pack_writer: IN_BYTES must lie in 1..TM");
  end

  pack_state_t         state;
  logic [ADDR_WIDTH:0] rows_q;
  logic [ADDR_WIDTH:0] rows_done;
  logic                wr_bank;

  logic                s_ready;
  logic                start_hs;
  logic                beat_hs;
  logic                append;
  logic                last_row;
  logic                final_row;
  logic                pk_clear;
  logic [CW-1:0]       pk_cnt;
  logic [CW-1:0]       pk_pre;
  logic                pk_row_ready;
  logic [TM*8-1:0]     pk_row_data;
  logic [1:0]          own_mask;
  logic [1:0]          rel_mask;
  logic [1:0]          set_mask;

  always_comb begin
    start_ready = (state == IDLE) && !bank_full[wr_bank];
    start_hs    = start_valid && start_ready;
    s_ready     = ((state == PACK) && (pk_cnt < CW'(TM))) || (state == DRAIN);
    beat_hs     = s_if.valid && s_ready;
    append      = beat_hs && (state == PACK);
    last_row    = (rows_done == rows_q - 1'b1);
    final_row   = (state == PACK) && pk_row_ready && last_row;
    // Residual bytes are dropped once the last row has gone out.
    pk_clear    = (state != PACK) || final_row;
    own_mask    = wr_bank ? 2'b10 : 2'b01;
    rel_mask    = bank_release & ~((state != IDLE) ? own_mask : 2'b00);
    set_mask    = (state == DONE) ? own_mask : 2'b00;
  end

  assign s_if.ready  = s_ready;
  assign bank_sel_wr = wr_bank;

  act_row_packer #(
    .TM       (TM),
    .IN_BYTES (IN_BYTES)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .append    (append),
    .beat      (s_if.data),
    .cnt       (pk_cnt),
    .pre_cnt   (pk_pre),
    .row_ready (pk_row_ready),
    .row_data  (pk_row_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rows_q        <= '0;
      rows_done     <= '0;
      wr_bank       <= 1'b0;
      bank_full     <= 2'b00;
      we            <= 1'b0;
      waddr         <= '0;
      wdata         <= '0;
      tile_done     <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      we        <= 1'b0;
      tile_done <= 1'b0;
      bank_full <= (bank_full & ~rel_mask) | set_mask;
      case (state)
        IDLE: begin
          if (start_hs) begin
            rows_q        <= cfg_rows;
            rows_done     <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            if (cfg_rows == '0) tile_done <= 1'b1;
            else                state     <= PACK;
          end
        end
        PACK: begin
          if (pk_row_ready) begin
            we        <= 1'b1;
            waddr     <= rows_done[ADDR_WIDTH-1:0];
            wdata     <= pk_row_data;
            rows_done <= rows_done + 1'b1;
          end
          if (final_row && (pk_pre > CW'(TM))) err_overflow <= 1'b1;
          if (beat_hs && s_if.last) begin
            if (final_row) begin
              state     <= DONE;
              tile_done <= 1'b1;
            end else begin
              err_underflow <= 1'b1;
              state         <= PAD;
            end
          end else if (final_row) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (beat_hs) begin
            err_overflow <= 1'b1;
            if (s_if.last) begin
              state     <= DONE;
              tile_done <= 1'b1;
            end
          end
        end
        PAD: begin
          // First pass writes the zero-padded residue, later passes all zeros.
          we        <= 1'b1;
          waddr     <= rows_done[ADDR_WIDTH-1:0];
          wdata     <= pk_row_data;
          rows_done <= rows_done + 1'b1;
          if (last_row) begin
            state     <= DONE;
            tile_done <= 1'b1;
          end
        end
        DONE: begin
          wr_bank <= ~wr_bank;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACT_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      if (beat_hs) stat_beats <= stat_beats + 32'd1;
      if ((s_if.valid && !s_ready) || (start_valid && !start_ready))
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_pack_writer.sv
// Directed bench for act_pack_writer: row-level model of expected SRAM writes plus literal pins.
module tb_act_pack_writer;

  localparam int TM = 14;
  localparam int IN = 4;
  localparam int AW = 7;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [TM*8-1:0] data;
    logic            bank;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_valid = 1'b0;
  logic            start_ready;
  logic [AW:0]     cfg_rows = '0;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [TM*8-1:0] wdata;
  logic            bank_sel_wr;
  logic [1:0]      bank_release = 2'b00;
  logic [1:0]      bank_full;
  logic            tile_done;
  logic            err_overflow;
  logic            err_underflow;
`ifdef ACT_PACK_STATS_EN
  logic [31:0]     stat_beats;
  logic [31:0]     stat_stall;
`endif

  act_pack_writer_if #(.IN_BYTES(IN)) s_if ();

  act_pack_writer #(.TM(TM), .ADDR_WIDTH(AW), .IN_BYTES(IN)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .cfg_rows      (cfg_rows),
    .s_if          (s_if),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .bank_sel_wr   (bank_sel_wr),
    .bank_release  (bank_release),
    .bank_full     (bank_full),
    .tile_done     (tile_done),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef ACT_PACK_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_stall    (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int              n_vec = 0;
  int              n_err = 0;
  wr_t             exp_q[$];
  logic [TM*8-1:0] got_q[$];
  logic            model_bank = 1'b0;
  logic            exp_o;
  logic            exp_u;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every SRAM write must match the next row the model predicted.
  always @(negedge clk) begin
    if (!rst && we) begin
      got_q.push_back(wdata);
      if (exp_q.size() == 0) begin
        chk("we_unexpected", {127'd0, we}, 128'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", {121'd0, waddr}, {121'd0, e.addr});
        chk("wdata", {16'd0, wdata}, {16'd0, e.data});
        chk("bank_sel_wr", {127'd0, bank_sel_wr}, {127'd0, e.bank});
      end
    end
  end

  // Tile as a byte stream: rows take stream bytes in order, missing bytes are zero.
  task automatic model_tile(input int rows, input int nbeats, input int first);
    int n;
    n = nbeats * IN;
    for (int r = 0; r < rows; r++) begin
      wr_t e;
      e.addr = AW'(r);
      e.data = '0;
      e.bank = model_bank;
      for (int j = 0; j < TM; j++) begin
        int idx;
        idx = r * TM + j;
        if (idx < n) e.data[8*j +: 8] = 8'(first + idx);
      end
      exp_q.push_back(e);
    end
    exp_u = (n < rows * TM);
    exp_o = (n > rows * TM);
  endtask

  task automatic start_tile(input int rows);
    int tries;
    @(negedge clk);
    start_valid = 1'b1;
    cfg_rows    = (AW+1)'(rows);
    tries = 0;
    while (!start_ready && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 100) chk("start_ready_timeout", {127'd0, start_ready}, 128'd1);
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input int first, input bit with_last);
    int tries;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_if.valid = 1'b1;
      for (int b = 0; b < IN; b++) s_if.data[8*b +: 8] = 8'(first + i * IN + b);
      s_if.last = with_last && (i == n - 1);
      tries = 0;
      while (!s_if.ready && tries < 100) begin
        @(negedge clk);
        tries++;
      end
      if (tries >= 100) begin
        chk("s_ready_timeout", {127'd0, s_if.ready}, 128'd1);
        break;
      end
      @(posedge clk);
    end
    #1;
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic wait_tile_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!tile_done && k < 300);
    chk("tile_done_seen", {127'd0, tile_done}, 128'd1);
  endtask

  // Called at the negedge of the tile_done cycle.
  task automatic finish_tile(input logic [1:0] exp_bf);
    @(negedge clk);
    chk("writes_left", 128'(exp_q.size()), 128'd0);
    chk("err_overflow", {127'd0, err_overflow}, {127'd0, exp_o});
    chk("err_underflow", {127'd0, err_underflow}, {127'd0, exp_u});
    model_bank = ~model_bank;
    chk("bank_sel_next", {127'd0, bank_sel_wr}, {127'd0, model_bank});
    chk("bank_full", {126'd0, bank_full}, {126'd0, exp_bf});
  endtask

  task automatic reset_checks();
    chk("rst_we", {127'd0, we}, 128'd0);
    chk("rst_tile_done", {127'd0, tile_done}, 128'd0);
    chk("rst_waddr", {121'd0, waddr}, 128'd0);
    chk("rst_wdata", {16'd0, wdata}, 128'd0);
    chk("rst_bank_sel", {127'd0, bank_sel_wr}, 128'd0);
    chk("rst_bank_full", {126'd0, bank_full}, 128'd0);
    chk("rst_errs", {126'd0, err_overflow, err_underflow}, 128'd0);
    chk("rst_start_ready", {127'd0, start_ready}, 128'd1);
    chk("rst_s_ready", {127'd0, s_if.ready}, 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
    s_if.data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks();

    // Exact fit: two full rows, bytes 0..27.
    got_q.delete();
    model_tile(2, 7, 0);
    start_tile(2);
    send_beats(7, 0, 1'b1);
    wait_tile_done();
    finish_tile(2'b01);
    chk("row0_literal", {16'd0, got_q[0]}, {16'd0, 112'h0d0c0b0a09080706050403020100});
    chk("row1_literal", {16'd0, got_q[1]}, {16'd0, 112'h1b1a191817161514131211100f0e});

    // Early s_last: second row zero-padded.
    got_q.delete();
    model_tile(2, 5, 0);
    start_tile(2);
    send_beats(5, 0, 1'b1);
    wait_tile_done();
    finish_tile(2'b11);
    chk("pad_literal", {16'd0, got_q[1]}, {16'd0, 112'h0000000000000000131211100f0e});

    // Both banks full: start must wait for the owning bank's release.
    model_tile(1, 6, 32);
    @(negedge clk);
    start_valid = 1'b1;
    cfg_rows    = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_blocked", {127'd0, start_ready}, 128'd0);
    end
    bank_release = 2'b10;
    @(posedge clk);
    #1 bank_release = 2'b00;
    @(negedge clk);
    chk("other_release_blocked", {127'd0, start_ready}, 128'd0);
    chk("bank_full_after_rel1", {126'd0, bank_full}, 128'd1);
    bank_release = 2'b01;
    @(posedge clk);
    #1 bank_release = 2'b00;
    @(negedge clk);
    chk("start_after_rel0", {127'd0, start_ready}, 128'd1);
    chk("bank_full_after_rel0", {126'd0, bank_full}, 128'd0);
    @(posedge clk);
    #1 start_valid = 1'b0;

    // One row, six beats: beats 5-6 drained, done right after the s_last handshake.
    send_beats(6, 32, 1'b1);
    @(negedge clk);
    chk("drain_done_timing", {127'd0, tile_done}, 128'd1);
    finish_tile(2'b01);

    // Zero-row tile: done pulse only.
    start_tile(0);
    @(negedge clk);
    chk("zero_rows_done", {127'd0, tile_done}, 128'd1);
    @(negedge clk);
    chk("zero_rows_pulse", {127'd0, tile_done}, 128'd0);
    chk("zero_rows_bank_full", {126'd0, bank_full}, 128'd1);
    chk("zero_rows_idle", {127'd0, start_ready}, 128'd1);
    chk("zero_rows_bank_sel", {127'd0, bank_sel_wr}, {127'd0, model_bank});

    // Reset in the middle of a tile abandons it.
    start_tile(2);
    send_beats(3, 64, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_bank = 1'b0;
    exp_q.delete();
    @(negedge clk);
    reset_checks();
    repeat (5) @(negedge clk);
    model_tile(2, 7, 128);
    start_tile(2);
    send_beats(7, 128, 1'b1);
    wait_tile_done();
    finish_tile(2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
